// File: rtl/m_ram8.sv
// Eight-word register memory: a dmux tree steers the load strobe to one word
// register, and a combinational 8:1 mux returns word[i_address].

module m_ram8_dmux (
  input  logic in,
  input  logic sel,
  output logic a,
  output logic b
);
  assign a = in & ~sel;
  assign b = in &  sel;
endmodule

module m_ram8_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end
endmodule

module m_ram8 #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [WIDTH-1:0]  i_in,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_address,
  output logic [WIDTH-1:0]  o_out
);
  logic [1:0]                  ld_l1;
  logic [3:0]                  ld_l2;
  logic [DEPTH-1:0]            ld_word;
  logic [DEPTH-1:0][WIDTH-1:0] words;

  // Decode tree: address MSB splits first, LSB last, so ld_word[k] fires only for address k.
  m_ram8_dmux u_dmux_l0 (.in(i_load), .sel(i_address[2]), .a(ld_l1[0]), .b(ld_l1[1]));

  genvar gi, gj, gw;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_l1
      m_ram8_dmux u_dmux (.in(ld_l1[gi]), .sel(i_address[1]),
                          .a(ld_l2[2*gi]), .b(ld_l2[2*gi+1]));
    end
    for (gj = 0; gj < 4; gj++) begin : g_l2
      m_ram8_dmux u_dmux (.in(ld_l2[gj]), .sel(i_address[0]),
                          .a(ld_word[2*gj]), .b(ld_word[2*gj+1]));
    end
    for (gw = 0; gw < DEPTH; gw++) begin : g_word
      m_ram8_word #(.WIDTH(WIDTH)) u_word (
        .clk (i_clk),
        .rst (i_rst),
        .load(ld_word[gw]),
        .d   (i_in),
        .q   (words[gw])
      );
    end
  endgenerate

  // No write-through: a same-address write shows up only after the edge.
  assign o_out = words[i_address];
endmodule

// File: tb/tb_m_ram8.sv
// Directed bench for m_ram8: stimulus queues expected read data, a negedge
// monitor pops and compares against o_out.

module tb_m_ram8;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] din = '0;
  logic        load = 1'b0;
  logic [2:0]  addr = '0;
  logic [15:0] dout;

  typedef struct {
    logic [15:0] exp;
    logic [2:0]  addr;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  logic mon_vld = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;
  int   n_issued = 0;

  always #5 clk = ~clk;

  m_ram8 dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_in     (din),
    .i_load   (load),
    .i_address(addr),
    .o_out    (dout)
  );

  // Monitor: o_out is sampled mid-cycle, i.e. before the edge that applies this cycle's write.
  always @(negedge clk) begin
    if (mon_vld) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL underflow: output presented with no expected entry, got %h", dout);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_vec++;
        if (dout !== e.exp) begin
          n_miss++;
          $display("FAIL vec%0d addr=%0d: got %h, expected %h", e.id, e.addr, dout, e.exp);
        end
      end
    end
  end

  task automatic cyc(input logic r, input logic ld, input logic [2:0] a,
                     input logic [15:0] d, input bit chk, input logic [15:0] exp);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; load = ld; addr = a; din = d;
    mon_vld = chk;
    if (chk) begin
      e.exp = exp; e.addr = a; e.id = n_issued;
      n_issued++;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    // 1 reset then sweep
    cyc(1'b1, 1'b0, 3'd0, 16'h0000, 1'b0, 16'h0000);
    for (int a = 0; a < 8; a++) cyc(1'b0, 1'b0, a[2:0], 16'h5555, 1'b1, 16'h0000);

    // 2 write all (mid-cycle read shows old cleared value), then read back
    for (int a = 0; a < 8; a++)
      cyc(1'b0, 1'b1, a[2:0], 16'hA000 + a[15:0], 1'b1, 16'h0000);
    for (int a = 0; a < 8; a++)
      cyc(1'b0, 1'b0, a[2:0], 16'h0000, 1'b1, 16'hA000 + a[15:0]);

    // 3 load gating
    cyc(1'b0, 1'b0, 3'd3, 16'hFFFF, 1'b1, 16'hA003);
    cyc(1'b0, 1'b0, 3'd3, 16'h0000, 1'b1, 16'hA003);

    // 4 read-during-write at address 5; neighbours untouched
    cyc(1'b0, 1'b1, 3'd5, 16'h1234, 1'b1, 16'hA005);
    cyc(1'b0, 1'b0, 3'd5, 16'h0000, 1'b1, 16'h1234);
    cyc(1'b0, 1'b0, 3'd4, 16'h0000, 1'b1, 16'hA004);
    cyc(1'b0, 1'b0, 3'd6, 16'h0000, 1'b1, 16'hA006);

    // 5 reset beats load
    cyc(1'b1, 1'b1, 3'd2, 16'hBEEF, 1'b1, 16'hA002);
    for (int a = 0; a < 8; a++) cyc(1'b0, 1'b0, a[2:0], 16'h0000, 1'b1, 16'h0000);

    // 6 back-to-back writes, then a write elsewhere
    cyc(1'b0, 1'b1, 3'd7, 16'h0001, 1'b1, 16'h0000);
    cyc(1'b0, 1'b1, 3'd7, 16'h0002, 1'b1, 16'h0001);
    cyc(1'b0, 1'b1, 3'd0, 16'h7FFF, 1'b1, 16'h0000);
    cyc(1'b0, 1'b0, 3'd7, 16'h0000, 1'b1, 16'h0002);
    cyc(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h7FFF);
    cyc(1'b0, 1'b0, 3'd1, 16'h0000, 1'b1, 16'h0000);

    @(posedge clk);
    #1;
    mon_vld = 1'b0;
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain: %0d expected entries never checked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1);
  end
endmodule
